rat_ctrl_multi_irq: RTL and testbench

RAT_CTRL_MULTI_IRQ -- requirements
Module: rat_ctrl_multi_irq

---
 rtl/rat_ctrl_pkg.sv | 66 ++++++
 rtl/rat_irq_arbiter.sv | 48 ++++
 rtl/rat_ctrl_multi_irq.sv | 155 +++++++++++++++
 tb/tb_rat_ctrl_multi_irq.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_ctrl_pkg.sv
// Shared types and constants for the RAT control unit: FSM states, opcodes,
// ALU codes and datapath mux selects.
package rat_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_INTR  = 2'd3
   } state_t;

   // Full 7-bit opcodes
   localparam logic [6:0] OP_AND_R  = 7'b0000000;
   localparam logic [6:0] OP_OR_R   = 7'b0000001;
   localparam logic [6:0] OP_EXOR_R = 7'b0000010;
   localparam logic [6:0] OP_ADD_R  = 7'b0000100;
   localparam logic [6:0] OP_MOV_R  = 7'b0001001;
   localparam logic [6:0] OP_BRN    = 7'b0010000;
   localparam logic [6:0] OP_CALL   = 7'b0010001;
   localparam logic [6:0] OP_BREQ   = 7'b0010010;
   localparam logic [6:0] OP_BRNE   = 7'b0010011;
   localparam logic [6:0] OP_BRCS   = 7'b0010100;
   localparam logic [6:0] OP_BRCC   = 7'b0010101;
   localparam logic [6:0] OP_PUSH   = 7'b0100101;
   localparam logic [6:0] OP_POP    = 7'b0100110;
   localparam logic [6:0] OP_CLC    = 7'b0110000;
   localparam logic [6:0] OP_SEC    = 7'b0110001;
   localparam logic [6:0] OP_RET    = 7'b0110010;
   localparam logic [6:0] OP_SEI    = 7'b0110100;
   localparam logic [6:0] OP_CLI    = 7'b0110101;
   localparam logic [6:0] OP_RETID  = 7'b0110110;
   localparam logic [6:0] OP_RETIE  = 7'b0110111;

   // Immediate / port forms: only the upper five opcode bits are decoded
   localparam logic [4:0] OPI_AND  = 5'b10000;
   localparam logic [4:0] OPI_OR   = 5'b10001;
   localparam logic [4:0] OPI_EXOR = 5'b10010;
   localparam logic [4:0] OPI_ADD  = 5'b10100;
   localparam logic [4:0] OPI_IN   = 5'b11001;
   localparam logic [4:0] OPI_OUT  = 5'b11010;
   localparam logic [4:0] OPI_MOV  = 5'b11011;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_AND  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_EXOR = 4'd7;
   localparam logic [3:0] ALU_MOV  = 4'd14;

   localparam logic [1:0] PCM_IMM   = 2'd0;
   localparam logic [1:0] PCM_STACK = 2'd1;
   localparam logic [1:0] PCM_VEC   = 2'd2;

   localparam logic [1:0] RFS_ALU = 2'd0;
   localparam logic [1:0] RFS_SCR = 2'd1;
   localparam logic [1:0] RFS_SP  = 2'd2;
   localparam logic [1:0] RFS_IN  = 2'd3;

   localparam logic [1:0] SCA_REG  = 2'd0;
   localparam logic [1:0] SCA_IMM  = 2'd1;
   localparam logic [1:0] SCA_SP   = 2'd2;
   localparam logic [1:0] SCA_SPM1 = 2'd3;

   localparam logic SCD_REG = 1'b0;
   localparam logic SCD_PC  = 1'b1;

endpackage

// File: rtl/rat_irq_arbiter.sv
// Rising-edge capture of the interrupt lines into pending bits, lowest-index
// priority selection, and the INT_ID latch for the source being serviced.
module rat_irq_arbiter #(
   parameter int NUM_IRQ = 4,
   parameter int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               service,
   output logic               irq_req,
   output logic [IRQ_W-1:0]   int_id
);

   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] win_mask;
   logic [IRQ_W-1:0]   win_id;

   // Scan from the top so the lowest pending index is the last assignment.
   always_comb begin
      win_id   = '0;
      win_mask = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pending[i]) begin
            win_id      = IRQ_W'(i);
            win_mask    = '0;
            win_mask[i] = 1'b1;
         end
      end
   end

   assign irq_req = |pending;

   // A fresh edge on the serviced line is OR-ed in after the clear, so it survives.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         irq_q   <= '0;
         pending <= '0;
         int_id  <= '0;
      end else begin
         irq_q   <= irq;
         pending <= (pending & ~(service ? win_mask : '0)) | (irq & ~irq_q);
         if (service) int_id <= win_id;
      end
   end

endmodule

// File: rtl/rat_ctrl_multi_irq.sv
// RAT CPU control unit with multiple edge-triggered interrupt sources.
// Strobes are a combinational decode of the present state and opcode.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_INIT  | reset the datapath (RST)
//   ST_FETCH | advance PC past the fetched instruction
//   ST_EXEC  | decode and execute; check for interrupt
//   ST_INTR  | push PC, shadow flags, jump to vector 0x3FF
module rat_ctrl_multi_irq
   import rat_ctrl_pkg::*;
#(
   parameter int NUM_IRQ = 4,
   parameter int IRQ_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [4:0]         OPCODE_HI_5,
   input  logic [1:0]         OPCODE_LOW_2,
   input  logic               C_FLAG,
   input  logic               Z_FLAG,
   input  logic [NUM_IRQ-1:0] IRQ,
   output logic               PC_LD,
   output logic               PC_INC,
   output logic               RST,
   output logic               IO_STRB,
   output logic               RF_WR,
   output logic               ALU_OPY_SEL,
   output logic               SP_LD,
   output logic               SP_INCR,
   output logic               SP_DECR,
   output logic               SCR_WE,
   output logic               SCR_DATA_SEL,
   output logic               FLG_C_SET,
   output logic               FLG_C_CLR,
   output logic               FLG_C_LD,
   output logic               FLG_Z_LD,
   output logic               FLG_LD_SEL,
   output logic               FLG_SHAD_LD,
   output logic [1:0]         PC_MUX_SEL,
   output logic [1:0]         RF_WR_SEL,
   output logic [1:0]         SCR_ADDR_SEL,
   output logic [3:0]         ALU_SEL,
   output logic               I_FLAG,
   output logic [IRQ_W-1:0]   INT_ID
);

   state_t     ps;
   logic       ie;
   logic       i_set;
   logic       i_clr;
   logic       irq_req;
   logic       take;
   logic [6:0] opcode;

   assign opcode = {OPCODE_HI_5, OPCODE_LOW_2};
   // Registered IE: an SEI/RETIE in this EXEC cannot enable its own interrupt.
   assign take   = (ps == ST_EXEC) && ie && irq_req;
   assign I_FLAG = ie;

   rat_irq_arbiter #(.NUM_IRQ(NUM_IRQ), .IRQ_W(IRQ_W)) u_arb (
      .CLK     (CLK),
      .RESET   (RESET),
      .irq     (IRQ),
      .service (take),
      .irq_req (irq_req),
      .int_id  (INT_ID)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         ps <= ST_INIT;
         ie <= 1'b0;
      end else begin
         case (ps)
            ST_INIT:  ps <= ST_FETCH;
            ST_FETCH: ps <= ST_EXEC;
            ST_EXEC:  ps <= take ? ST_INTR : ST_FETCH;
            default:  ps <= ST_FETCH;
         endcase
         if (i_clr)      ie <= 1'b0;
         else if (i_set) ie <= 1'b1;
      end
   end

   always_comb begin
      PC_LD = 1'b0;        PC_INC = 1'b0;       RST = 1'b0;
      IO_STRB = 1'b0;      RF_WR = 1'b0;        ALU_OPY_SEL = 1'b0;
      SP_LD = 1'b0;        SP_INCR = 1'b0;      SP_DECR = 1'b0;
      SCR_WE = 1'b0;       SCR_DATA_SEL = SCD_REG;
      FLG_C_SET = 1'b0;    FLG_C_CLR = 1'b0;    FLG_C_LD = 1'b0;
      FLG_Z_LD = 1'b0;     FLG_LD_SEL = 1'b0;   FLG_SHAD_LD = 1'b0;
      PC_MUX_SEL = PCM_IMM; RF_WR_SEL = RFS_ALU; SCR_ADDR_SEL = SCA_REG;
      ALU_SEL = ALU_ADD;
      i_set = 1'b0;        i_clr = 1'b0;
      case (ps)
         ST_INIT:  RST = 1'b1;
         ST_FETCH: PC_INC = 1'b1;
         ST_EXEC: begin
            case (opcode)
               OP_ADD_R:  begin RF_WR = 1'b1; FLG_Z_LD = 1'b1; FLG_C_LD = 1'b1;  ALU_SEL = ALU_ADD;  end
               OP_AND_R:  begin RF_WR = 1'b1; FLG_Z_LD = 1'b1; FLG_C_CLR = 1'b1; ALU_SEL = ALU_AND;  end
               OP_OR_R:   begin RF_WR = 1'b1; FLG_Z_LD = 1'b1; FLG_C_CLR = 1'b1; ALU_SEL = ALU_OR;   end
               OP_EXOR_R: begin RF_WR = 1'b1; FLG_Z_LD = 1'b1; FLG_C_CLR = 1'b1; ALU_SEL = ALU_EXOR; end
               OP_MOV_R:  begin RF_WR = 1'b1; ALU_SEL = ALU_MOV; end
               OP_BRN:    PC_LD = 1'b1;
               OP_BREQ:   PC_LD = Z_FLAG;
               OP_BRNE:   PC_LD = ~Z_FLAG;
               OP_BRCS:   PC_LD = C_FLAG;
               OP_BRCC:   PC_LD = ~C_FLAG;
               OP_CALL: begin
                  PC_LD = 1'b1; SCR_WE = 1'b1; SCR_DATA_SEL = SCD_PC;
                  SCR_ADDR_SEL = SCA_SPM1; SP_DECR = 1'b1;
               end
               OP_RET, OP_RETID, OP_RETIE: begin
                  PC_LD = 1'b1; PC_MUX_SEL = PCM_STACK; SCR_ADDR_SEL = SCA_SP; SP_INCR = 1'b1;
                  if (opcode != OP_RET) begin
                     FLG_LD_SEL = 1'b1; FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
                  end
                  i_clr = (opcode == OP_RETID);
                  i_set = (opcode == OP_RETIE);
               end
               OP_PUSH: begin SCR_WE = 1'b1; SCR_ADDR_SEL = SCA_SPM1; SP_DECR = 1'b1; end
               OP_POP:  begin RF_WR = 1'b1; RF_WR_SEL = RFS_SCR; SCR_ADDR_SEL = SCA_SP; SP_INCR = 1'b1; end
               OP_SEC:  FLG_C_SET = 1'b1;
               OP_CLC:  FLG_C_CLR = 1'b1;
               OP_SEI:  i_set = 1'b1;
               OP_CLI:  i_clr = 1'b1;
               default: begin
                  case (opcode[6:2])
                     OPI_ADD:  begin RF_WR = 1'b1; ALU_OPY_SEL = 1'b1; FLG_Z_LD = 1'b1; FLG_C_LD = 1'b1;  ALU_SEL = ALU_ADD;  end
                     OPI_AND:  begin RF_WR = 1'b1; ALU_OPY_SEL = 1'b1; FLG_Z_LD = 1'b1; FLG_C_CLR = 1'b1; ALU_SEL = ALU_AND;  end
                     OPI_OR:   begin RF_WR = 1'b1; ALU_OPY_SEL = 1'b1; FLG_Z_LD = 1'b1; FLG_C_CLR = 1'b1; ALU_SEL = ALU_OR;   end
                     OPI_EXOR: begin RF_WR = 1'b1; ALU_OPY_SEL = 1'b1; FLG_Z_LD = 1'b1; FLG_C_CLR = 1'b1; ALU_SEL = ALU_EXOR; end
                     OPI_MOV:  begin RF_WR = 1'b1; ALU_OPY_SEL = 1'b1; ALU_SEL = ALU_MOV; end
                     OPI_IN:   begin RF_WR = 1'b1; RF_WR_SEL = RFS_IN; end
                     OPI_OUT:  IO_STRB = 1'b1;
                     default:  ;
                  endcase
               end
            endcase
         end
         ST_INTR: begin
            PC_LD = 1'b1; PC_MUX_SEL = PCM_VEC; SCR_WE = 1'b1; SCR_DATA_SEL = SCD_PC;
            SCR_ADDR_SEL = SCA_SPM1; SP_DECR = 1'b1; FLG_SHAD_LD = 1'b1; i_clr = 1'b1;
         end
         default: ;
      endcase
   end

   // RF_WR_SEL=SP is reserved for a future instruction; SP is never loaded here.
   logic unused_rfs;
   assign unused_rfs = ^RFS_SP ^ ^SCA_IMM;

endmodule

// File: tb/tb_rat_ctrl_multi_irq.sv
// Bench for rat_ctrl_multi_irq: instruction table doubling as reference model,
// directed interrupt/reset sequences, then randomized cycles against the model.
module tb_rat_ctrl_multi_irq;
   localparam int NI = 4;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic [4:0] OPCODE_HI_5 = '0;
   logic [1:0] OPCODE_LOW_2 = '0;
   logic C_FLAG = 1'b0, Z_FLAG = 1'b0;
   logic [NI-1:0] IRQ = '0;
   logic PC_LD, PC_INC, RST, IO_STRB, RF_WR, ALU_OPY_SEL, SP_LD, SP_INCR, SP_DECR;
   logic SCR_WE, SCR_DATA_SEL, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD;
   logic [1:0] PC_MUX_SEL, RF_WR_SEL, SCR_ADDR_SEL;
   logic [3:0] ALU_SEL;
   logic I_FLAG;
   logic [1:0] INT_ID;

   rat_ctrl_multi_irq #(.NUM_IRQ(NI)) dut (
      .CLK(CLK), .RESET(RESET), .OPCODE_HI_5(OPCODE_HI_5), .OPCODE_LOW_2(OPCODE_LOW_2),
      .C_FLAG(C_FLAG), .Z_FLAG(Z_FLAG), .IRQ(IRQ),
      .PC_LD(PC_LD), .PC_INC(PC_INC), .RST(RST), .IO_STRB(IO_STRB), .RF_WR(RF_WR),
      .ALU_OPY_SEL(ALU_OPY_SEL), .SP_LD(SP_LD), .SP_INCR(SP_INCR), .SP_DECR(SP_DECR),
      .SCR_WE(SCR_WE), .SCR_DATA_SEL(SCR_DATA_SEL), .FLG_C_SET(FLG_C_SET),
      .FLG_C_CLR(FLG_C_CLR), .FLG_C_LD(FLG_C_LD), .FLG_Z_LD(FLG_Z_LD),
      .FLG_LD_SEL(FLG_LD_SEL), .FLG_SHAD_LD(FLG_SHAD_LD), .PC_MUX_SEL(PC_MUX_SEL),
      .RF_WR_SEL(RF_WR_SEL), .SCR_ADDR_SEL(SCR_ADDR_SEL), .ALU_SEL(ALU_SEL),
      .I_FLAG(I_FLAG), .INT_ID(INT_ID)
   );

   always #5 CLK = ~CLK;

   logic [26:0] outs;
   assign outs = {PC_LD, PC_INC, RST, IO_STRB, RF_WR, ALU_OPY_SEL, SP_LD, SP_INCR, SP_DECR,
                  SCR_WE, SCR_DATA_SEL, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL,
                  FLG_SHAD_LD, PC_MUX_SEL, RF_WR_SEL, SCR_ADDR_SEL, ALU_SEL};

   localparam logic [26:0] B_PC_LD  = 27'h1 << 26, B_PC_INC = 27'h1 << 25, B_RST   = 27'h1 << 24;
   localparam logic [26:0] B_IO     = 27'h1 << 23, B_RF_WR  = 27'h1 << 22, B_OPY   = 27'h1 << 21;
   localparam logic [26:0] B_SP_INC = 27'h1 << 19, B_SP_DEC = 27'h1 << 18, B_SCR_WE = 27'h1 << 17;
   localparam logic [26:0] B_SCR_PC = 27'h1 << 16, B_C_SET  = 27'h1 << 15, B_C_CLR = 27'h1 << 14;
   localparam logic [26:0] B_C_LD   = 27'h1 << 13, B_Z_LD   = 27'h1 << 12, B_LDSEL = 27'h1 << 11;
   localparam logic [26:0] B_SHAD   = 27'h1 << 10;

   function automatic logic [26:0] pcm(input int v); return 27'(v) << 8; endfunction
   function automatic logic [26:0] rfs(input int v); return 27'(v) << 6; endfunction
   function automatic logic [26:0] sca(input int v); return 27'(v) << 4; endfunction
   function automatic logic [26:0] alu(input int v); return 27'(v); endfunction

   localparam logic [26:0] V_INIT  = B_RST;
   localparam logic [26:0] V_FETCH = B_PC_INC;
   localparam logic [6:0]  NOP     = 7'b1111111;

   // cond: 0 always, 1 Z=1, 2 Z=0, 3 C=1, 4 C=0.  ief: 0 none, 1 IE<=1, 2 IE<=0
   typedef struct {
      logic [6:0]  opc;
      logic [6:0]  care;
      int          cond;
      int          ief;
      logic [26:0] exp;
   } ent_t;
   ent_t tbl[$];

   function automatic void add(input logic [6:0] opc, input logic [6:0] care, input int cond,
                               input int ief, input logic [26:0] exp);
      ent_t e;
      e.opc = opc; e.care = care; e.cond = cond; e.ief = ief; e.exp = exp;
      tbl.push_back(e);
   endfunction

   function automatic int lookup(input logic [6:0] op);
      for (int i = 0; i < tbl.size(); i++)
         if ((op & tbl[i].care) == (tbl[i].opc & tbl[i].care)) return i;
      return -1;
   endfunction

   function automatic logic [26:0] exec_exp(input logic [6:0] op, input logic c, input logic z);
      int i;
      logic ok;
      i = lookup(op);
      if (i < 0) return '0;
      case (tbl[i].cond)
         1: ok = z;
         2: ok = !z;
         3: ok = c;
         4: ok = !c;
         default: ok = 1'b1;
      endcase
      return ok ? tbl[i].exp : '0;
   endfunction

   int total = 0;
   int bad = 0;
   logic [6:0] op_v;
   logic c_v = 1'b0, z_v = 1'b0, rst_v = 1'b1;
   logic [NI-1:0] irq_v = '0;
   logic [26:0] V_INTR;

   task automatic chk_v(input string nm, input logic [26:0] exp);
      total++;
      if (outs !== exp) begin
         bad++;
         $display("FAIL %s: got strobes %h, want %h (t=%0t)", nm, outs, exp, $time);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle's inputs on the falling edge and settle before sampling.
   task automatic cyc(input logic [6:0] op);
      @(negedge CLK);
      RESET = rst_v;
      {OPCODE_HI_5, OPCODE_LOW_2} = op;
      C_FLAG = c_v;
      Z_FLAG = z_v;
      IRQ = irq_v;
      #1;
   endtask

   // Leaves the bench having just sampled the FETCH cycle after reset.
   task automatic do_reset();
      rst_v = 1'b1; irq_v = '0;
      cyc(NOP);
      rst_v = 1'b0;
      cyc(NOP);
      cyc(NOP);
   endtask

   // Reference model state
   int m_ph;
   logic m_ie;
   logic [NI-1:0] m_pend, m_prev;
   int m_id;

   initial begin
      V_INTR = B_PC_LD | pcm(2) | B_SCR_WE | B_SCR_PC | sca(3) | B_SP_DEC | B_SHAD;

      add(7'b0000100, 7'h7F, 0, 0, B_RF_WR | B_C_LD | B_Z_LD | alu(0));
      add(7'b1010000, 7'h7C, 0, 0, B_RF_WR | B_OPY | B_C_LD | B_Z_LD | alu(0));
      add(7'b0000000, 7'h7F, 0, 0, B_RF_WR | B_Z_LD | B_C_CLR | alu(5));
      add(7'b1000000, 7'h7C, 0, 0, B_RF_WR | B_OPY | B_Z_LD | B_C_CLR | alu(5));
      add(7'b0000001, 7'h7F, 0, 0, B_RF_WR | B_Z_LD | B_C_CLR | alu(6));
      add(7'b1000100, 7'h7C, 0, 0, B_RF_WR | B_OPY | B_Z_LD | B_C_CLR | alu(6));
      add(7'b0000010, 7'h7F, 0, 0, B_RF_WR | B_Z_LD | B_C_CLR | alu(7));
      add(7'b1001000, 7'h7C, 0, 0, B_RF_WR | B_OPY | B_Z_LD | B_C_CLR | alu(7));
      add(7'b0001001, 7'h7F, 0, 0, B_RF_WR | alu(14));
      add(7'b1101100, 7'h7C, 0, 0, B_RF_WR | B_OPY | alu(14));
      add(7'b1100100, 7'h7C, 0, 0, B_RF_WR | rfs(3));
      add(7'b1101000, 7'h7C, 0, 0, B_IO);
      add(7'b0010000, 7'h7F, 0, 0, B_PC_LD);
      add(7'b0010010, 7'h7F, 1, 0, B_PC_LD);
      add(7'b0010011, 7'h7F, 2, 0, B_PC_LD);
      add(7'b0010100, 7'h7F, 3, 0, B_PC_LD);
      add(7'b0010101, 7'h7F, 4, 0, B_PC_LD);
      add(7'b0010001, 7'h7F, 0, 0, B_PC_LD | B_SCR_WE | B_SCR_PC | sca(3) | B_SP_DEC);
      add(7'b0110010, 7'h7F, 0, 0, B_PC_LD | pcm(1) | sca(2) | B_SP_INC);
      add(7'b0110110, 7'h7F, 0, 2, B_PC_LD | pcm(1) | sca(2) | B_SP_INC | B_LDSEL | B_C_LD | B_Z_LD);
      add(7'b0110111, 7'h7F, 0, 1, B_PC_LD | pcm(1) | sca(2) | B_SP_INC | B_LDSEL | B_C_LD | B_Z_LD);
      add(7'b0100101, 7'h7F, 0, 0, B_SCR_WE | sca(3) | B_SP_DEC);
      add(7'b0100110, 7'h7F, 0, 0, B_RF_WR | rfs(1) | sca(2) | B_SP_INC);
      add(7'b0110001, 7'h7F, 0, 0, B_C_SET);
      add(7'b0110000, 7'h7F, 0, 0, B_C_CLR);
      add(7'b0110100, 7'h7F, 0, 1, '0);
      add(7'b0110101, 7'h7F, 0, 2, '0);

      // Reset: INIT then FETCH, interrupts disabled
      rst_v = 1'b1; cyc(NOP);
      rst_v = 1'b0;
      cyc(NOP);
      chk_v("reset_init", V_INIT);
      chk_i("reset_iflag", int'(I_FLAG), 0);
      chk_i("reset_intid", int'(INT_ID), 0);
      cyc(NOP);
      chk_v("reset_fetch", V_FETCH);

      // Table sweep: EXEC decode of every instruction, then back to FETCH
      foreach (tbl[i]) begin
         op_v = (tbl[i].opc & tbl[i].care) | (7'($urandom) & ~tbl[i].care);
         c_v = 1'($urandom); z_v = 1'($urandom);
         cyc(op_v);
         chk_v($sformatf("tbl_exec_%0d_op%b", i, op_v), exec_exp(op_v, c_v, z_v));
         cyc(NOP);
         chk_v($sformatf("tbl_fetch_%0d", i), V_FETCH);
      end
      cyc(NOP);
      chk_v("undecoded_exec", '0);
      cyc(NOP);
      chk_v("undecoded_to_fetch", V_FETCH);

      // BREQ on both Z values
      z_v = 1'b0; cyc(7'b0010010); chk_v("breq_z0", '0);
      cyc(NOP);
      z_v = 1'b1; cyc(7'b0010010); chk_v("breq_z1", B_PC_LD | pcm(0));
      cyc(NOP);

      // PUSH then POP
      cyc(7'b0100101); chk_v("push", B_SCR_WE | sca(3) | B_SP_DEC);
      cyc(NOP);
      cyc(7'b0100110); chk_v("pop", B_RF_WR | rfs(1) | sca(2) | B_SP_INC);
      cyc(NOP);

      // SEI then two simultaneous sources: lowest first, next after RETIE
      do_reset();
      cyc(7'b0110100);
      irq_v = 4'b0110;
      cyc(NOP);
      cyc(NOP);
      cyc(NOP);
      chk_v("intr1_vec", V_INTR);
      chk_i("intr1_id", int'(INT_ID), 1);
      cyc(NOP);
      chk_v("intr1_ret_fetch", V_FETCH);
      chk_i("intr1_iflag", int'(I_FLAG), 0);
      cyc(7'b0110111);
      cyc(NOP);
      chk_v("retie_no_same_exec", V_FETCH);
      chk_i("retie_iflag", int'(I_FLAG), 1);
      cyc(NOP);
      cyc(NOP);
      chk_v("intr2_vec", V_INTR);
      chk_i("intr2_id", int'(INT_ID), 2);
      cyc(NOP);

      // Edge while disabled stays pending until SEI plus one instruction
      do_reset();
      irq_v = 4'b0001;
      cyc(NOP);
      cyc(NOP);
      chk_v("ie0_no_intr", V_FETCH);
      cyc(NOP);
      cyc(NOP);
      chk_v("ie0_still_no_intr", V_FETCH);
      cyc(7'b0110100);
      cyc(NOP);
      chk_v("sei_same_exec", V_FETCH);
      cyc(NOP);
      cyc(NOP);
      chk_v("held_pend_intr", V_INTR);
      chk_i("held_pend_id", int'(INT_ID), 0);
      cyc(NOP);

      // Reset during INTR clears pending work
      do_reset();
      cyc(7'b0110100);
      irq_v = 4'b1010;
      cyc(NOP);
      cyc(NOP);
      rst_v = 1'b1; irq_v = '0;
      cyc(NOP);
      chk_v("intr_before_rst", V_INTR);
      chk_i("intr_before_rst_id", int'(INT_ID), 1);
      rst_v = 1'b0;
      cyc(NOP);
      chk_v("rst_in_intr", V_INIT);
      chk_i("rst_in_intr_iflag", int'(I_FLAG), 0);
      chk_i("rst_in_intr_id", int'(INT_ID), 0);
      cyc(NOP);
      cyc(7'b0110100);
      cyc(NOP);
      cyc(NOP);
      cyc(NOP);
      chk_v("pend_cleared_by_rst", V_FETCH);

      // New edge in the cycle its pending bit is cleared remains pending
      do_reset();
      irq_v = 4'b0001;
      cyc(7'b0110100);
      irq_v = '0;
      cyc(NOP);
      irq_v = 4'b0001;
      cyc(NOP);
      cyc(NOP);
      chk_v("edge_clr_first", V_INTR);
      cyc(NOP);
      cyc(7'b0110111);
      cyc(NOP);
      cyc(NOP);
      cyc(NOP);
      chk_v("edge_clr_repend", V_INTR);
      chk_i("edge_clr_id", int'(INT_ID), 0);

      // Randomized cycles against the model
      do_reset();
      m_ph = 2; m_ie = 1'b0; m_pend = '0; m_prev = '0; m_id = 0;
      for (int n = 0; n < 1500; n++) begin
         logic take;
         int idx, w;
         logic [26:0] exp;
         rst_v = ($urandom_range(0, 59) == 0);
         c_v = 1'($urandom); z_v = 1'($urandom);
         for (int k = 0; k < NI; k++)
            if ($urandom_range(0, 5) == 0) irq_v[k] = ~irq_v[k];
         if ($urandom_range(0, 1) == 1) begin
            idx = $urandom_range(0, tbl.size() - 1);
            op_v = (tbl[idx].opc & tbl[idx].care) | (7'($urandom) & ~tbl[idx].care);
         end else begin
            op_v = 7'($urandom);
         end
         cyc(op_v);

         case (m_ph)
            0: exp = V_INIT;
            1: exp = V_FETCH;
            2: exp = exec_exp(op_v, c_v, z_v);
            default: exp = V_INTR;
         endcase
         chk_v($sformatf("rnd%0d_strobes_ph%0d_op%b", n, m_ph, op_v), exp);
         chk_i($sformatf("rnd%0d_iflag", n), int'(I_FLAG), int'(m_ie));
         chk_i($sformatf("rnd%0d_intid", n), int'(INT_ID), m_id);

         if (rst_v) begin
            m_ph = 0; m_ie = 1'b0; m_pend = '0; m_prev = '0; m_id = 0;
         end else begin
            take = (m_ph == 2) && m_ie && (m_pend != '0);
            if (m_ph == 2) begin
               idx = lookup(op_v);
               if (idx >= 0 && tbl[idx].ief == 1) m_ie = 1'b1;
               if (idx >= 0 && tbl[idx].ief == 2) m_ie = 1'b0;
            end
            if (m_ph == 3) m_ie = 1'b0;
            if (take) begin
               w = -1;
               for (int k = 0; k < NI; k++)
                  if (w < 0 && m_pend[k]) w = k;
               m_pend[w] = 1'b0;
               m_id = w;
            end
            for (int k = 0; k < NI; k++)
               if (irq_v[k] && !m_prev[k]) m_pend[k] = 1'b1;
            m_prev = irq_v;
            case (m_ph)
               0: m_ph = 1;
               1: m_ph = 2;
               2: m_ph = take ? 3 : 1;
               default: m_ph = 1;
            endcase
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
